// File: rtl/vrased_log_reader.sv
// VRASED violation-log reader: dumps the log RAM as a byte stream (count header + 5 bytes/record), then clears the RAM.
// Optional CRC-8 trailer byte when VRASED_LOG_READER_CRC_EN is defined.
module vrased_log_reader #(
  parameter logic [15:0] LOG_DEPTH = 16'h0100,
  parameter int          REC_W     = 38
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      wr_count,
  output logic             re,
  output logic [15:0]      rd_addr,
  input  logic [REC_W-1:0] rd_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             clr_ram
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_HDR_HI  = 4'd1;
  localparam logic [3:0] ST_HDR_LO  = 4'd2;
  localparam logic [3:0] ST_READ    = 4'd3;
  localparam logic [3:0] ST_CAPTURE = 4'd4;
  localparam logic [3:0] ST_SEND    = 4'd5;
  localparam logic [3:0] ST_CLEAR   = 4'd6;
  localparam logic [3:0] ST_DONE    = 4'd7;
`ifdef VRASED_LOG_READER_CRC_EN
  localparam logic [3:0] ST_CRC     = 4'd8;

  logic [7:0] crc;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction
`endif

  logic [3:0]  state;
  logic [15:0] n;
  logic [31:0] sr;
  logic [2:0]  byte_cnt;
  logic [15:0] n_cap;
  logic [39:0] rec40;
  logic        xfer;

  assign n_cap = (wr_count > LOG_DEPTH) ? LOG_DEPTH : wr_count;
  assign rec40 = {{(40-REC_W){1'b0}}, rd_data};
  assign xfer  = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      n        <= '0;
      rd_addr  <= '0;
      sr       <= '0;
      byte_cnt <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      re       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      clr_ram  <= 1'b0;
`ifdef VRASED_LOG_READER_CRC_EN
      crc      <= '0;
`endif
    end else begin
      re      <= 1'b0;
      done    <= 1'b0;
      clr_ram <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          n        <= n_cap;
          rd_addr  <= '0;
          busy     <= 1'b1;
          tx_valid <= 1'b1;
          tx_data  <= n_cap[15:8];
          state    <= ST_HDR_HI;
`ifdef VRASED_LOG_READER_CRC_EN
          crc      <= '0;
`endif
        end
        ST_HDR_HI: if (xfer) begin
`ifdef VRASED_LOG_READER_CRC_EN
          crc     <= crc8(crc, tx_data);
`endif
          tx_data <= n[7:0];
          state   <= ST_HDR_LO;
        end
        ST_HDR_LO: if (xfer) begin
`ifdef VRASED_LOG_READER_CRC_EN
          crc <= crc8(crc, tx_data);
`endif
          if (n == 16'd0) begin
`ifdef VRASED_LOG_READER_CRC_EN
            tx_data  <= crc8(crc, tx_data);
            state    <= ST_CRC;
`else
            tx_valid <= 1'b0;
            clr_ram  <= 1'b1;
            state    <= ST_CLEAR;
`endif
          end else begin
            tx_valid <= 1'b0;
            re       <= 1'b1;
            state    <= ST_READ;
          end
        end
        ST_READ: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          // RAM data is valid this cycle (one after re); first byte goes straight out.
          tx_data  <= rec40[39:32];
          sr       <= rec40[31:0];
          byte_cnt <= '0;
          tx_valid <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: if (xfer) begin
`ifdef VRASED_LOG_READER_CRC_EN
          crc <= crc8(crc, tx_data);
`endif
          if (byte_cnt == 3'd4) begin
            rd_addr <= rd_addr + 16'd1;
            if (rd_addr + 16'd1 == n) begin
`ifdef VRASED_LOG_READER_CRC_EN
              tx_data  <= crc8(crc, tx_data);
              state    <= ST_CRC;
`else
              tx_valid <= 1'b0;
              clr_ram  <= 1'b1;
              state    <= ST_CLEAR;
`endif
            end else begin
              tx_valid <= 1'b0;
              re       <= 1'b1;
              state    <= ST_READ;
            end
          end else begin
            tx_data  <= sr[31:24];
            sr       <= {sr[23:0], 8'h00};
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
`ifdef VRASED_LOG_READER_CRC_EN
        ST_CRC: if (xfer) begin
          tx_valid <= 1'b0;
          clr_ram  <= 1'b1;
          state    <= ST_CLEAR;
        end
`endif
        ST_CLEAR: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vrased_log_reader.sv
// Randomized self-checking bench for vrased_log_reader: RAM model, byte-stream monitor, queue-based reference.
module tb_vrased_log_reader;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, tx_ready = 1'b0;
  logic [15:0] wr_count = '0;
  logic        re, tx_valid, busy, done, clr_ram;
  logic [15:0] rd_addr;
  logic [37:0] rd_data = '0;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  vrased_log_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .wr_count(wr_count),
    .re(re), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .clr_ram(clr_ram)
  );

`ifdef VRASED_LOG_READER_CRC_EN
  localparam int CRC_B = 1;
`else
  localparam int CRC_B = 0;
`endif

  logic [37:0] ram [0:1023];
  always @(posedge clk) if (re) rd_data <= ram[rd_addr[9:0]];

  int checks = 0, errors = 0;
  int rdy_mode = 0;
  always @(negedge clk)
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase

  // Stream monitor: collects transferred bytes, read addresses, pulses; checks stall stability.
  logic [7:0]  got[$];
  logic [7:0]  exp[$];
  logic [15:0] addrs[$];
  int clr_cnt = 0, done_cnt = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;
  always @(posedge clk) begin
    if (reset_n) begin
      if (pv && !pr) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== pd) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, pd);
        end
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (re) addrs.push_back(rd_addr);
      if (clr_ram) clr_cnt++;
      if (done) done_cnt++;
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end else pv = 1'b0;
  end

  // Reference: header, 5 bytes per record MSB first, optional CRC-8 by bitwise long division.
  task automatic build_exp(input int wr);
    int n;
    logic [39:0] w;
    logic [7:0] c;
    logic fb;
    n = (wr > 256) ? 256 : wr;
    exp.delete();
    exp.push_back(8'((n >> 8) & 255));
    exp.push_back(8'(n & 255));
    for (int i = 0; i < n; i++) begin
      w = {2'b00, ram[i]};
      for (int b = 0; b < 5; b++) exp.push_back(w[39-8*b -: 8]);
    end
    if (CRC_B == 1) begin
      c = 8'h00;
      foreach (exp[k])
        for (int bit_i = 7; bit_i >= 0; bit_i--) begin
          fb = c[7] ^ exp[k][bit_i];
          c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
      exp.push_back(c);
    end
  endtask

  task automatic run_dump(input int wr, input int max_cyc, input int poke);
    got.delete(); addrs.delete(); clr_cnt = 0; done_cnt = 0;
    @(negedge clk);
    wr_count = 16'(wr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) begin
      if (i == poke) begin start = 1'b1; wr_count = 16'(wr + 3); end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL dump_timeout: done not seen within %0d cycles (wr=%0d)", max_cyc, wr);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({re, tx_valid, busy, done, clr_ram} !== 5'b0 || tx_data !== 8'h00 || rd_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: re=%b v=%b busy=%b done=%b clr=%b data=%h addr=%h, required all 0",
               re, tx_valid, busy, done, clr_ram, tx_data, rd_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty;
    rdy_mode = 0;
    run_dump(0, 50, -1);
    build_exp(0);
    checks++;
    if (got.size() != exp.size()) begin
      errors++; $display("FAIL empty_len: got %0d bytes, required %0d", got.size(), exp.size());
    end else foreach (exp[i]) if (got[i] !== exp[i]) begin
      errors++; $display("FAIL empty_byte%0d: got %h, required %h", i, got[i], exp[i]);
    end
    checks++;
    if (addrs.size() != 0 || clr_cnt != 1 || done_cnt != 1) begin
      errors++; $display("FAIL empty_pulses: re=%0d clr=%0d done=%0d, required 0 1 1", addrs.size(), clr_cnt, done_cnt);
    end
  endtask

  task automatic test_two_timing;
    int clrk;
    logic ok_v1, ok_re2, ok_re3, ok_d5, ok_clr, ok_done;
    ram[0] = 38'h3F_0000_0001; ram[1] = 38'h00_DEAD_BEEF;
    rdy_mode = 0;
    got.delete(); addrs.delete(); clr_cnt = 0; done_cnt = 0;
    clrk = 17 + CRC_B;
    @(negedge clk);
    wr_count = 16'd2; start = 1'b1;
    ok_v1 = 0; ok_re2 = 0; ok_re3 = 0; ok_d5 = 0; ok_clr = 0; ok_done = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) ok_v1 = (tx_valid === 1'b1 && tx_data === 8'h00 && busy === 1'b1);
      if (k == 2) ok_re2 = (re === 1'b0);
      if (k == 3) ok_re3 = (re === 1'b1 && rd_addr === 16'h0);
      if (k == 5) ok_d5 = (tx_valid === 1'b1 && tx_data === 8'h3F);
      if (k == clrk) ok_clr = (clr_ram === 1'b1 && done === 1'b0);
      if (k == clrk + 1) ok_done = (done === 1'b1 && clr_ram === 1'b0);
    end
    checks++;
    if (!(ok_v1 && ok_re2 && ok_re3 && ok_d5 && ok_clr && ok_done)) begin
      errors++; $display("FAIL two_timing: v1=%b re2=%b re3=%b d5=%b clr=%b done=%b, required all 1",
                         ok_v1, ok_re2, ok_re3, ok_d5, ok_clr, ok_done);
    end
    build_exp(2);
    checks++;
    if (got.size() != exp.size()) begin
      errors++; $display("FAIL two_len: got %0d bytes, required %0d", got.size(), exp.size());
    end else foreach (exp[i]) if (got[i] !== exp[i]) begin
      errors++; $display("FAIL two_byte%0d: got %h, required %h", i, got[i], exp[i]);
    end
    checks++;
    if (addrs.size() != 2 || addrs[0] !== 16'd0 || addrs[1] !== 16'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL two_reads: %0d reads, busy=%b, required reads at 0,1 and busy=0", addrs.size(), busy);
    end
  endtask

  task automatic test_stall;
    rdy_mode = 1;
    run_dump(2, 200, -1);
    build_exp(2);
    checks++;
    if (got.size() != exp.size()) begin
      errors++; $display("FAIL stall_len: got %0d bytes, required %0d", got.size(), exp.size());
    end else foreach (exp[i]) if (got[i] !== exp[i]) begin
      errors++; $display("FAIL stall_byte%0d: got %h, required %h", i, got[i], exp[i]);
    end
  endtask

  task automatic test_cap;
    int bad;
    for (int i = 0; i < 1024; i++) ram[i] = {6'($urandom), 32'($urandom)};
    rdy_mode = 0;
    run_dump(16'h0300, 2200, -1);
    build_exp(16'h0300);
    checks++;
    if (got.size() != exp.size() || got[0] !== 8'h01 || got[1] !== 8'h00) begin
      errors++; $display("FAIL cap_header: len %0d hdr %h%h, required len %0d hdr 0100",
                         got.size(), got[0], got[1], exp.size());
    end else foreach (exp[i]) if (got[i] !== exp[i]) begin
      errors++; $display("FAIL cap_byte%0d: got %h, required %h", i, got[i], exp[i]);
    end
    bad = 0;
    foreach (addrs[i]) if (addrs[i] !== 16'(i)) bad++;
    checks++;
    if (addrs.size() != 256 || bad != 0) begin
      errors++; $display("FAIL cap_reads: %0d reads, %0d out of order, required 256 at 0..255", addrs.size(), bad);
    end
  endtask

  task automatic test_random;
    int wr;
    for (int it = 0; it < 5; it++) begin
      wr = $urandom_range(1, 12);
      for (int i = 0; i < 16; i++) ram[i] = {6'($urandom), 32'($urandom)};
      rdy_mode = 2;
      run_dump(wr, 600, -1);
      build_exp(wr);
      checks++;
      if (got.size() != exp.size()) begin
        errors++; $display("FAIL rand%0d_len: got %0d bytes, required %0d", it, got.size(), exp.size());
      end else foreach (exp[i]) if (got[i] !== exp[i]) begin
        errors++; $display("FAIL rand%0d_byte%0d: got %h, required %h", it, i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_crc_busy_start;
    ram[0] = 38'h31_3233_3435;
    rdy_mode = 0;
    run_dump(1, 60, 4);
    build_exp(1);
    checks++;
    if (got.size() != exp.size()) begin
      errors++; $display("FAIL crc_len: got %0d bytes, required %0d", got.size(), exp.size());
    end else foreach (exp[i]) if (got[i] !== exp[i]) begin
      errors++; $display("FAIL crc_byte%0d: got %h, required %h", i, got[i], exp[i]);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != 1 || clr_cnt != 1 || busy !== 1'b0 || got.size() != exp.size()) begin
      errors++; $display("FAIL busy_start_ignored: done=%0d clr=%0d busy=%b len=%0d, required 1 1 0 %0d",
                         done_cnt, clr_cnt, busy, got.size(), exp.size());
    end
  endtask

  task automatic test_reset_mid;
    ram[0] = 38'h12_3456_789A; ram[1] = 38'h2B_CDEF_0123;
    rdy_mode = 0;
    got.delete(); addrs.delete(); clr_cnt = 0; done_cnt = 0;
    @(negedge clk);
    wr_count = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && got.size() < 8; i++) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({re, tx_valid, busy, done, clr_ram} !== 5'b0 || tx_data !== 8'h00 || rd_addr !== 16'h0) begin
      errors++; $display("FAIL midreset_outputs: re=%b v=%b busy=%b done=%b clr=%b data=%h addr=%h, required all 0",
                         re, tx_valid, busy, done, clr_ram, tx_data, rd_addr);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (clr_cnt != 0 || done_cnt != 0 || got.size() != 8) begin
      errors++; $display("FAIL midreset_abort: clr=%0d done=%0d bytes=%0d, required 0 0 8", clr_cnt, done_cnt, got.size());
    end
    run_dump(2, 100, -1);
    build_exp(2);
    checks++;
    if (got.size() != exp.size()) begin
      errors++; $display("FAIL fresh_len: got %0d bytes, required %0d", got.size(), exp.size());
    end else foreach (exp[i]) if (got[i] !== exp[i]) begin
      errors++; $display("FAIL fresh_byte%0d: got %h, required %h", i, got[i], exp[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    test_reset;
    test_empty;
    test_two_timing;
    test_stall;
    test_cap;
    test_random;
    test_crc_busy_start;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vrased_log_reader.md
# vrased_log_reader

Drains the VRASED violation log RAM to a host-side byte stream. On a start request it reads every valid 38-bit log record over the RAM read port and serializes each record as five bytes on a valid/ready byte interface. The stream is preceded by a two-byte record count. When the dump completes, the block pulses the RAM clear. It sits beside the violation logger: the logger writes records, and this block is the reader end of the same RAM.

## Interface
Parameters:
- LOG_DEPTH, 16'h0100, number of RAM entries; caps the dumped record count
- REC_W, 38, log record width; fixed, must match the RAM read data width

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  dump request; sampled only in IDLE
- wr_count  in  16  number of records currently held by the logger
- re  out  1  RAM read enable, one-cycle pulse per record
- rd_addr  out  16  RAM read address
- rd_data  in  38  RAM read data, valid the cycle after re
- tx_data  out  8  stream byte
- tx_valid  out  1  stream byte valid
- tx_ready  in  1  stream sink ready
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of dump
- clr_ram  out  1  one-cycle RAM clear pulse

## Operation
- States: IDLE, HDR_HI, HDR_LO, READ, CAPTURE, SEND, CRC (macro only), CLEAR, DONE.
- IDLE → HDR_HI on start. In the same edge:
  - latch n = min(wr_count, LOG_DEPTH)
  - rd_addr := 0, busy := 1
- HDR_HI sends n[15:8]. HDR_LO sends n[7:0].
- After HDR_LO is accepted:
  - if n == 0, go to CRC (macro on) or CLEAR (macro off)
  - otherwise go to READ
- READ: assert re for exactly one cycle at the current rd_addr, then go to CAPTURE.
- CAPTURE: load the 40-bit shift register with {2'b00, rd_data}, then go to SEND.
- SEND: five bytes, MSB first, shift register [39:32] down to [7:0]. After byte 5 is accepted:
  - rd_addr increments
  - if rd_addr + 1 == n, go to CRC or CLEAR
  - otherwise go to READ
- CLEAR: clr_ram = 1 for one cycle, then go to DONE.
- DONE: done = 1 for one cycle. busy is deasserted as the block returns to IDLE.
- start while busy is ignored. wr_count changes during a dump are ignored; n is latched.
- Handshake rules:
  - a byte transfers on a clk edge where tx_valid && tx_ready
  - tx_data is held stable while tx_valid && !tx_ready
  - tx_valid never drops before the transfer completes
- rd_addr is 16-bit unsigned. n ≤ LOG_DEPTH guarantees no wrap.
- Reset:
  - all outputs go to 0, rd_addr to 0, state to IDLE
  - a reset mid-dump aborts immediately; the partial stream is not completed and clr_ram is not pulsed

## Timing
- start high at edge t → tx_valid = 1 with count high byte from cycle t+1.
- With tx_ready held high:
  - header bytes accepted at edges t+1 and t+2
  - re high in cycle t+3
  - rd_data captured at edge t+4
  - first record byte valid from cycle t+5
- Per record, with tx_ready high: 7 cycles (READ, CAPTURE, 5 SEND).
- Total dump with tx_ready high: 2 + 7n (+1 CRC) cycles, then CLEAR and DONE.
- The tx_ready-to-transfer path is combinational only through the tx_valid && tx_ready enable. No output depends combinationally on any input.

## Configuration
- VRASED_LOG_READER_CRC_EN defined:
  - after the last record, or after the header when n == 0, send one trailer byte
  - trailer is CRC-8: poly 0x07, init 0x00, no reflection, no final XOR
  - CRC covers every previously transmitted byte of this dump, header included
  - CRC register resets on each accepted start
- Not defined: the CRC state and logic are absent; the last data byte goes directly to CLEAR.

## Test plan
- wr_count = 0, start pulse, tx_ready = 1 → bytes 00 00 (plus CRC 00 with the macro), one clr_ram pulse, then one done pulse. re never asserted.
- wr_count = 2, RAM[0] = 38'h3F_0000_0001, RAM[1] = 38'h00_DEAD_BEEF → bytes 00 02 3F 00 00 00 01 00 DE AD BE EF. re pulses at rd_addr 0, then 1.
- Same as the previous scenario with tx_ready toggling 1/0 every cycle → identical byte sequence, tx_data stable through every stall, no byte duplicated or dropped.
- wr_count = 16'h0300 with LOG_DEPTH = 16'h0100 → header 01 00, exactly 256 records read at addresses 0..255.
- Macro on, wr_count = 1, RAM[0] = 38'h31_3233_3435 → bytes 00 01 31 32 33 34 35 then the CRC-8/SMBUS of 00 01 31 32 33 34 35, checked against the reference model. Start asserted mid-dump → ignored.
- reset_n low during SEND of record 1 → all outputs 0 the next cycle, no clr_ram, no done. A subsequent start produces a complete fresh dump.
